mem_arbiter: RTL and testbench

//  Shares the single-port main memory between the CPU and one secondary
//  bus master (DMA / program loader). The CPU has no stall input, so the CPU
//  has absolute priority. The secondary master is granted only on cycles

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has absolute priority, DMA gets idle cycles; grant is combinational,
// read data returns 1 cycle after mem_re. DMA backpressure is dma_gnt=0; the DMA holds its request until granted.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_byt,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_en,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_byt,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_starved,
  output logic              mem_re,
  output logic              mem_we,
  output logic              mem_byt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic OWNER_CPU = 1'b0;

  logic              cpu_act;
  logic              rd_pend_q;
  logic              rd_owner_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_nxt;
  logic              starved_q;

  assign cpu_act = cpu_rd | cpu_wr;
  assign dma_gnt = dma_en & dma_req & ~cpu_act & ~rst;

  // CPU fields also drive the bus when idle, so addr/data only toggle on DMA grants.
  always_comb begin
    mem_re    = cpu_rd;
    mem_we    = cpu_wr;
    mem_byt   = cpu_byt;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (!cpu_act && dma_gnt) begin
      mem_re    = ~dma_we;
      mem_we    = dma_we;
      mem_byt   = dma_byt;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // A read in flight across reset must not surface as a DMA return.
  assign dma_rvalid = rd_pend_q & rd_owner_q & ~rst;
  assign dma_rdata  = dma_rvalid ? mem_rdata : rdata_q;
  assign cpu_rdata  = mem_rdata;

  always_comb begin
    wait_nxt = wait_cnt;
    if (dma_gnt || !dma_req || !dma_en) begin
      wait_nxt = '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_nxt = wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_CPU;
      rdata_q    <= '0;
      wait_cnt   <= '0;
      starved_q  <= 1'b0;
    end else begin
      rd_pend_q  <= mem_re;
      rd_owner_q <= dma_gnt;
      if (dma_rvalid) begin
        rdata_q <= mem_rdata;
      end
      wait_cnt  <= wait_nxt;
      starved_q <= (wait_nxt == CNT_MAX);
    end
  end

  assign dma_starved = starved_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency memory model; STARVE_LIMIT=4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr, cpu_byt;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_en, dma_req, dma_we, dma_byt;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_starved;
  logic [15:0] dma_rdata;
  logic        mem_re, mem_we, mem_byt;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byt(cpu_byt),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dma_en(dma_en), .dma_req(dma_req), .dma_we(dma_we), .dma_byt(dma_byt),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dma_starved(dma_starved),
    .mem_re(mem_re), .mem_we(mem_we), .mem_byt(mem_byt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
    if (mem_we) begin
      if (mem_byt) mem[mem_addr[9:0]] <= {mem[mem_addr[9:0]][15:8], mem_wdata[7:0]};
      else         mem[mem_addr[9:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem[10'h100] = 16'hBEEF;
    mem[10'h101] = 16'hCAFE;
    mem[10'h020] = 16'h1234;
    mem_rdata = 16'h0;
    rst = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_byt = 0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_en = 0; dma_req = 0; dma_we = 0; dma_byt = 0; dma_addr = 16'h0; dma_wdata = 16'h0;

    // Reset state, and no grant while rst is high
    next_cycle(); next_cycle();
    dma_en = 1; dma_req = 1; dma_addr = 16'h0100;
    #1;
    chk("rst_rvalid",  32'(dma_rvalid),  32'd0);
    chk("rst_starved", 32'(dma_starved), 32'd0);
    chk("rst_rdata",   32'(dma_rdata),   32'd0);
    chk("rst_gnt",     32'(dma_gnt),     32'd0);

    // 1: DMA read of 0x100 while CPU idle
    next_cycle();
    rst = 0;
    #1;
    chk("t1_gnt",   32'(dma_gnt),  32'd1);
    chk("t1_re",    32'(mem_re),   32'd1);
    chk("t1_we",    32'(mem_we),   32'd0);
    chk("t1_addr",  32'(mem_addr), 32'h0100);
    next_cycle();
    dma_req = 0;
    #1;
    chk("t1_rvalid", 32'(dma_rvalid), 32'd1);
    chk("t1_rdata",  32'(dma_rdata),  32'hBEEF);
    next_cycle(); #1;
    chk("t1_rvalid_off", 32'(dma_rvalid), 32'd0);
    chk("t1_rdata_hold", 32'(dma_rdata),  32'hBEEF);

    // 5: dma_en=0 suppresses grants and the wait counter
    dma_en = 0; dma_req = 1;
    #1;
    chk("t5_gnt", 32'(dma_gnt), 32'd0);
    chk("t5_re",  32'(mem_re),  32'd0);
    chk("t5_we",  32'(mem_we),  32'd0);
    for (int i = 0; i < 5; i++) next_cycle();
    #1;
    chk("t5_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    chk("t5_starved",  32'(dma_starved),  32'd0);

    // 2: CPU read wins over a pending DMA read
    dma_en = 1; dma_addr = 16'h0101;
    cpu_rd = 1; cpu_addr = 16'h0020;
    #1;
    chk("t2_gnt",  32'(dma_gnt),  32'd0);
    chk("t2_addr", 32'(mem_addr), 32'h0020);
    next_cycle();
    #1;
    chk("t2_cpu_rdata", 32'(cpu_rdata),  32'h1234);
    chk("t2_rvalid",    32'(dma_rvalid), 32'd0);
    cpu_rd = 0;
    #1;
    chk("t2_gnt_on_fall", 32'(dma_gnt),  32'd1);
    chk("t2_dma_addr",    32'(mem_addr), 32'h0101);

    // 3: CPU read right behind the DMA read
    next_cycle();
    dma_req = 0; cpu_rd = 1; cpu_addr = 16'h0020;
    #1;
    chk("t3_rvalid", 32'(dma_rvalid), 32'd1);
    chk("t3_rdata",  32'(dma_rdata),  32'hCAFE);
    chk("t3_gnt",    32'(dma_gnt),    32'd0);
    next_cycle();
    cpu_rd = 0;
    #1;
    chk("t3_cpu_rdata",  32'(cpu_rdata),  32'h1234);
    chk("t3_rvalid_off", 32'(dma_rvalid), 32'd0);
    chk("t3_rdata_hold", 32'(dma_rdata),  32'hCAFE);

    // 4: CPU writes starve the DMA; flag sets after 4 waits, clears after grant
    next_cycle();
    dma_req = 1; dma_we = 0; dma_addr = 16'h0102;
    cpu_wr = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h7777;
    #1;
    chk("t4_mem_we",    32'(mem_we),    32'd1);
    chk("t4_mem_wdata", 32'(mem_wdata), 32'h7777);
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); #1;
      chk("t4_not_starved", 32'(dma_starved), 32'd0);
    end
    next_cycle(); #1;
    chk("t4_starved", 32'(dma_starved), 32'd1);
    next_cycle(); #1;
    chk("t4_sat_cnt",  32'(dut.wait_cnt), 32'd4);
    chk("t4_starved2", 32'(dma_starved),  32'd1);
    cpu_wr = 0;
    #1;
    chk("t4_gnt",          32'(dma_gnt),     32'd1);
    chk("t4_starved_gnt",  32'(dma_starved), 32'd1);
    next_cycle();
    dma_req = 0;
    #1;
    chk("t4_starved_clr", 32'(dma_starved), 32'd0);
    chk("t4_rdata",       32'(dma_rdata),   32'(16'h0102 ^ 16'hA5A5));

    // 6: reset right after a DMA read grant drops the return
    next_cycle();
    dma_req = 1; dma_addr = 16'h0100;
    #1;
    chk("t6_gnt", 32'(dma_gnt), 32'd1);
    next_cycle();
    rst = 1; dma_req = 0;
    #1;
    chk("t6_rvalid_in_rst", 32'(dma_rvalid), 32'd0);
    next_cycle();
    rst = 0;
    #1;
    chk("t6_rvalid_after", 32'(dma_rvalid), 32'd0);
    chk("t6_starved",      32'(dma_starved), 32'd0);
    chk("t6_rdata",        32'(dma_rdata),   32'd0);

    // DMA byte write is visible in its grant cycle only
    dma_req = 1; dma_we = 1; dma_byt = 1; dma_addr = 16'h0040; dma_wdata = 16'h00AB;
    #1;
    chk("t6_wr_gnt",   32'(dma_gnt),   32'd1);
    chk("t6_wr_we",    32'(mem_we),    32'd1);
    chk("t6_wr_re",    32'(mem_re),    32'd0);
    chk("t6_wr_byt",   32'(mem_byt),   32'd1);
    chk("t6_wr_wdata", 32'(mem_wdata), 32'h00AB);
    next_cycle();
    dma_req = 0; dma_we = 0; dma_byt = 0;
    #1;
    chk("t6_wr_we_off",  32'(mem_we),     32'd0);
    chk("t6_wr_byt_off", 32'(mem_byt),    32'd0);
    chk("t6_wr_rvalid",  32'(dma_rvalid), 32'd0);

    // Illegal cpu_rd & cpu_wr passes straight through and blocks the DMA
    dma_req = 1;
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 16'h0055;
    #1;
    chk("ill_re",   32'(mem_re),   32'd1);
    chk("ill_we",   32'(mem_we),   32'd1);
    chk("ill_gnt",  32'(dma_gnt),  32'd0);
    chk("ill_addr", 32'(mem_addr), 32'h0055);
    next_cycle();
    cpu_rd = 0; cpu_wr = 0; dma_req = 0;
    #1;
    chk("ill_rvalid", 32'(dma_rvalid), 32'd0);

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
